// File: rtl/exc_ctrl.sv
// Exception entry / ERET sequencer beside CP0.
// Picks the oldest stage request, flushes, writes CP0, redirects fetch.

package exc_pkg;

  localparam logic [4:0] EXC_INT     = 5'h00;
  localparam logic [4:0] ADDR_ERR_F  = 5'h04;
  localparam logic [4:0] ADDR_ERR_M  = 5'h05;
  localparam logic [4:0] BUS_ERR_F   = 5'h06;
  localparam logic [4:0] BUS_ERR_M   = 5'h07;
  localparam logic [4:0] SYSCALL     = 5'h08;
  localparam logic [4:0] BREAK       = 5'h09;
  localparam logic [4:0] RESV_INSTR  = 5'h0a;
  localparam logic [4:0] OVERFLOW    = 5'h0c;
  localparam logic [4:0] CACHE_ERR_F = 5'h1e;
  localparam logic [4:0] CACHE_ERR_M = 5'h1f;

endpackage

module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
  parameter logic [31:0] CERR_VECTOR = 32'hBFC0_0300
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   exc_valid,
  input  logic [19:0]  exc_code,
  input  logic [127:0] exc_pc,
  input  logic [3:0]   exc_bd,
  input  logic [63:0]  exc_vaddr,
  input  logic         eret_req,
  input  logic         status_exl,
  input  logic [31:0]  epc_in,
  output logic         flush,
  output logic         busy,
  output logic         cause_we,
  output logic [4:0]   cause_excode,
  output logic         cause_bd,
  output logic         epc_we,
  output logic [31:0]  epc_out,
  output logic         badvaddr_we,
  output logic [31:0]  badvaddr_out,
  output logic         exl_set,
  output logic         exl_clr,
  output logic         redirect_valid,
  output logic [31:0]  redirect_pc,
  input  logic         redirect_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_SAVE,
    S_ERET,
    S_REDIR
  } state_t;

  state_t state;

  logic [4:0]  sel_code;
  logic [31:0] sel_pc;
  logic        sel_bd;
  logic        sel_addr;
  logic        sel_cerr;
  logic [31:0] sel_vaddr;
  logic [31:0] sel_epc;

  logic        cap_bv;
  logic        cap_cerr;

  // oldest request wins: M, then E, then D, then F
  always_comb begin
    sel_code = '0;
    sel_pc   = '0;
    sel_bd   = 1'b0;
    priority case (1'b1)
      exc_valid[3]: begin
        sel_code = exc_code[19:15];
        sel_pc   = exc_pc[127:96];
        sel_bd   = exc_bd[3];
      end
      exc_valid[2]: begin
        sel_code = exc_code[14:10];
        sel_pc   = exc_pc[95:64];
        sel_bd   = exc_bd[2];
      end
      exc_valid[1]: begin
        sel_code = exc_code[9:5];
        sel_pc   = exc_pc[63:32];
        sel_bd   = exc_bd[1];
      end
      exc_valid[0]: begin
        sel_code = exc_code[4:0];
        sel_pc   = exc_pc[31:0];
        sel_bd   = exc_bd[0];
      end
      default: begin
        sel_code = '0;
        sel_pc   = '0;
        sel_bd   = 1'b0;
      end
    endcase
  end

  // classify the winner: address errors log BadVAddr, cache errors use their own vector
  always_comb begin
    sel_addr  = 1'b0;
    sel_cerr  = 1'b0;
    sel_vaddr = exc_vaddr[31:0];
    if (sel_code == ADDR_ERR_F) begin
      sel_addr  = 1'b1;
      sel_vaddr = exc_vaddr[31:0];
    end else if (sel_code == ADDR_ERR_M) begin
      sel_addr  = 1'b1;
      sel_vaddr = exc_vaddr[63:32];
    end
    if (sel_code == CACHE_ERR_F ||
        sel_code == CACHE_ERR_M) begin
      sel_cerr = 1'b1;
    end
  end

  // a delay-slot exception restarts at the branch, one word back
  assign sel_epc = sel_bd ? (sel_pc - 32'd4) : sel_pc;

  assign busy = (state != S_IDLE);

  // sequencer: strobes default low each cycle and pulse for one state only
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      flush          <= 1'b0;
      cause_we       <= 1'b0;
      cause_excode   <= '0;
      cause_bd       <= 1'b0;
      epc_we         <= 1'b0;
      epc_out        <= '0;
      badvaddr_we    <= 1'b0;
      badvaddr_out   <= '0;
      exl_set        <= 1'b0;
      exl_clr        <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      cap_bv         <= 1'b0;
      cap_cerr       <= 1'b0;
    end else begin
      flush       <= 1'b0;
      cause_we    <= 1'b0;
      epc_we      <= 1'b0;
      badvaddr_we <= 1'b0;
      exl_set     <= 1'b0;
      exl_clr     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (|exc_valid) begin
            cause_excode <= sel_code;
            cause_bd     <= sel_bd;
            epc_out      <= sel_epc;
            cap_bv       <= sel_addr;
            cap_cerr     <= sel_cerr;
            if (sel_addr) begin
              badvaddr_out <= sel_vaddr;
            end
            flush <= 1'b1;
            state <= S_FLUSH;
          end else if (eret_req) begin
            flush   <= 1'b1;
            exl_clr <= 1'b1;
            state   <= S_ERET;
          end
        end
        S_FLUSH: begin
          cause_we    <= 1'b1;
          exl_set     <= 1'b1;
          epc_we      <= !status_exl;
          badvaddr_we <= cap_bv;
          state       <= S_SAVE;
        end
        S_SAVE: begin
          redirect_valid <= 1'b1;
          redirect_pc    <= cap_cerr ? CERR_VECTOR
                                     : EXC_VECTOR;
          state          <= S_REDIR;
        end
        S_ERET: begin
          redirect_valid <= 1'b1;
          redirect_pc    <= epc_in;
          state          <= S_REDIR;
        end
        S_REDIR: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            state          <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl.
// Expected CP0 writes and redirect targets go through a scoreboard queue.

module tb_exc_ctrl;
  import exc_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   exc_valid;
  logic [19:0]  exc_code;
  logic [127:0] exc_pc;
  logic [3:0]   exc_bd;
  logic [63:0]  exc_vaddr;
  logic         eret_req;
  logic         status_exl;
  logic [31:0]  epc_in;
  logic         flush;
  logic         busy;
  logic         cause_we;
  logic [4:0]   cause_excode;
  logic         cause_bd;
  logic         epc_we;
  logic [31:0]  epc_out;
  logic         badvaddr_we;
  logic [31:0]  badvaddr_out;
  logic         exl_set;
  logic         exl_clr;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         redirect_ready;

  typedef struct {
    logic        is_eret;
    logic [4:0]  excode;
    logic        bd;
    logic        epc_we;
    logic [31:0] epc;
    logic        bv_we;
    logic [31:0] bv;
    logic [31:0] target;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   fails  = 0;

  exc_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .exc_valid      (exc_valid),
    .exc_code       (exc_code),
    .exc_pc         (exc_pc),
    .exc_bd         (exc_bd),
    .exc_vaddr      (exc_vaddr),
    .eret_req       (eret_req),
    .status_exl     (status_exl),
    .epc_in         (epc_in),
    .flush          (flush),
    .busy           (busy),
    .cause_we       (cause_we),
    .cause_excode   (cause_excode),
    .cause_bd       (cause_bd),
    .epc_we         (epc_we),
    .epc_out        (epc_out),
    .badvaddr_we    (badvaddr_we),
    .badvaddr_out   (badvaddr_out),
    .exl_set        (exl_set),
    .exl_clr        (exl_clr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    exc_valid = '0;
    exc_code  = '0;
    exc_pc    = '0;
    exc_bd    = '0;
    exc_vaddr = '0;
    eret_req  = 1'b0;
  endtask

  // full exception sequence with redirect_ready held high
  task automatic run_exc(input string tag,
                         input logic [3:0] v,
                         input logic [19:0] c,
                         input logic [127:0] p,
                         input logic [3:0] b,
                         input logic [63:0] va,
                         input logic exl,
                         input logic eret,
                         input exp_t e);
    exp_t got;
    int   n;
    exc_valid  = v;
    exc_code   = c;
    exc_pc     = p;
    exc_bd     = b;
    exc_vaddr  = va;
    status_exl = exl;
    eret_req   = eret;
    sb.push_back(e);
    tick();
    idle_inputs();
    chk({tag, ".flush"}, 32'(flush), 32'd1);
    chk({tag, ".busy1"}, 32'(busy), 32'd1);
    chk({tag, ".noclr"}, 32'(exl_clr), 32'd0);
    chk({tag, ".early_we"}, 32'(cause_we), 32'd0);
    tick();
    n = 0;
    while (!cause_we && n < 4) begin
      tick();
      n++;
    end
    chk({tag, ".we_lat"}, 32'(n), 32'd0);
    got = sb.pop_front();
    chk({tag, ".cause_we"}, 32'(cause_we), 32'd1);
    chk({tag, ".exl_set"}, 32'(exl_set), 32'd1);
    chk({tag, ".flush0"}, 32'(flush), 32'd0);
    chk({tag, ".excode"}, 32'(cause_excode),
        32'(got.excode));
    chk({tag, ".bd"}, 32'(cause_bd), 32'(got.bd));
    chk({tag, ".epc_we"}, 32'(epc_we),
        32'(got.epc_we));
    chk({tag, ".epc"}, epc_out, got.epc);
    chk({tag, ".bv_we"}, 32'(badvaddr_we),
        32'(got.bv_we));
    if (got.bv_we) begin
      chk({tag, ".bv"}, badvaddr_out, got.bv);
    end
    tick();
    chk({tag, ".rv"}, 32'(redirect_valid), 32'd1);
    chk({tag, ".rpc"}, redirect_pc, got.target);
    chk({tag, ".we_off"}, 32'(cause_we), 32'd0);
    tick();
    chk({tag, ".idle"}, 32'(busy), 32'd0);
    chk({tag, ".rv0"}, 32'(redirect_valid), 32'd0);
  endtask

  function automatic exp_t mk(logic [4:0] c,
                              logic b,
                              logic ew,
                              logic [31:0] ep,
                              logic bw,
                              logic [31:0] bv,
                              logic [31:0] t);
    exp_t e;
    e.is_eret = 1'b0;
    e.excode  = c;
    e.bd      = b;
    e.epc_we  = ew;
    e.epc     = ep;
    e.bv_we   = bw;
    e.bv      = bv;
    e.target  = t;
    return e;
  endfunction

  initial begin
    exp_t e;
    idle_inputs();
    rst            = 1'b1;
    status_exl     = 1'b0;
    epc_in         = '0;
    redirect_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.flush", 32'(flush), 32'd0);
    chk("rst.rv", 32'(redirect_valid), 32'd0);
    chk("rst.rpc", redirect_pc, 32'd0);
    chk("rst.epc", epc_out, 32'd0);

    // M-stage address error logs BadVAddr from the M address
    run_exc("t1", 4'b1000,
            {ADDR_ERR_M, 15'd0},
            {32'h8000_0010, 96'd0}, 4'b0000,
            {32'h1234_5671, 32'hdead_beef}, 1'b0, 1'b0,
            mk(ADDR_ERR_M, 1'b0, 1'b1, 32'h8000_0010,
               1'b1, 32'h1234_5671, 32'hBFC0_0380));

    // E is older than F
    run_exc("t2", 4'b0101,
            {5'd0, OVERFLOW, 5'd0, BUS_ERR_F},
            {32'd0, 32'h8000_0100, 32'd0, 32'h8000_0108},
            4'b0000, 64'd0, 1'b0, 1'b0,
            mk(OVERFLOW, 1'b0, 1'b1, 32'h8000_0100,
               1'b0, 32'd0, 32'hBFC0_0380));

    // all four stages: M wins
    run_exc("old", 4'b1111,
            {SYSCALL, BREAK, RESV_INSTR, BUS_ERR_F},
            {32'h8000_0200, 32'h8000_0204,
             32'h8000_0208, 32'h8000_020c},
            4'b0000, 64'd0, 1'b0, 1'b0,
            mk(SYSCALL, 1'b0, 1'b1, 32'h8000_0200,
               1'b0, 32'd0, 32'hBFC0_0380));

    // delay slot in D, EPC steps back one word
    run_exc("bd1", 4'b0010,
            {10'd0, SYSCALL, 5'd0},
            {64'd0, 32'h8000_0000, 32'd0}, 4'b0010,
            64'd0, 1'b0, 1'b0,
            mk(SYSCALL, 1'b1, 1'b1, 32'h7FFF_FFFC,
               1'b0, 32'd0, 32'hBFC0_0380));

    // delay slot at pc 0 wraps
    run_exc("bd0", 4'b0010,
            {10'd0, BREAK, 5'd0},
            128'd0, 4'b0010, 64'd0, 1'b0, 1'b0,
            mk(BREAK, 1'b1, 1'b1, 32'hFFFF_FFFC,
               1'b0, 32'd0, 32'hBFC0_0380));

    // nested exception keeps old EPC
    run_exc("exl", 4'b0100,
            {5'd0, OVERFLOW, 10'd0},
            {32'd0, 32'h8000_0300, 64'd0}, 4'b0000,
            64'd0, 1'b1, 1'b0,
            mk(OVERFLOW, 1'b0, 1'b0, 32'h8000_0300,
               1'b0, 32'd0, 32'hBFC0_0380));
    status_exl = 1'b0;

    run_exc("cerrm", 4'b1000,
            {CACHE_ERR_M, 15'd0},
            {32'h8000_0400, 96'd0}, 4'b0000,
            64'd0, 1'b0, 1'b0,
            mk(CACHE_ERR_M, 1'b0, 1'b1, 32'h8000_0400,
               1'b0, 32'd0, 32'hBFC0_0300));

    run_exc("cerrf", 4'b0001,
            {15'd0, CACHE_ERR_F},
            {96'd0, 32'h8000_0500}, 4'b0000,
            64'd0, 1'b0, 1'b0,
            mk(CACHE_ERR_F, 1'b0, 1'b1, 32'h8000_0500,
               1'b0, 32'd0, 32'hBFC0_0300));

    // F-stage address error logs the F address
    run_exc("adef", 4'b0001,
            {15'd0, ADDR_ERR_F},
            {96'd0, 32'h8000_0602}, 4'b0000,
            {32'h1111_1111, 32'h8000_0602},
            1'b0, 1'b0,
            mk(ADDR_ERR_F, 1'b0, 1'b1, 32'h8000_0602,
               1'b1, 32'h8000_0602, 32'hBFC0_0380));

    // ERET
    eret_req = 1'b1;
    epc_in   = 32'h8000_1000;
    e        = mk(5'd0, 1'b0, 1'b0, 32'd0,
                  1'b0, 32'd0, 32'h8000_1000);
    e.is_eret = 1'b1;
    sb.push_back(e);
    tick();
    eret_req = 1'b0;
    chk("eret.flush", 32'(flush), 32'd1);
    chk("eret.clr", 32'(exl_clr), 32'd1);
    chk("eret.noset", 32'(exl_set), 32'd0);
    chk("eret.nowe", 32'(cause_we), 32'd0);
    tick();
    e = sb.pop_front();
    chk("eret.kind", 32'(e.is_eret), 32'd1);
    chk("eret.rv", 32'(redirect_valid), 32'd1);
    chk("eret.rpc", redirect_pc, e.target);
    chk("eret.clr0", 32'(exl_clr), 32'd0);
    tick();
    chk("eret.idle", 32'(busy), 32'd0);

    // exception beats ERET in the same cycle
    run_exc("both", 4'b0100,
            {5'd0, OVERFLOW, 10'd0},
            {32'd0, 32'h8000_0700, 64'd0}, 4'b0000,
            64'd0, 1'b0, 1'b1,
            mk(OVERFLOW, 1'b0, 1'b1, 32'h8000_0700,
               1'b0, 32'd0, 32'hBFC0_0380));

    // fetch stalls the redirect for three cycles
    redirect_ready = 1'b0;
    exc_valid = 4'b1000;
    exc_code  = {SYSCALL, 15'd0};
    exc_pc    = {32'h8000_0800, 96'd0};
    tick();
    idle_inputs();
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("hold.rv", 32'(redirect_valid), 32'd1);
      chk("hold.rpc", redirect_pc, 32'hBFC0_0380);
      chk("hold.busy", 32'(busy), 32'd1);
      if (i < 2) tick();
    end
    redirect_ready = 1'b1;
    tick();
    chk("hold.idle", 32'(busy), 32'd0);
    chk("hold.rv0", 32'(redirect_valid), 32'd0);

    // reset while in SAVE
    exc_valid = 4'b1000;
    exc_code  = {ADDR_ERR_M, 15'd0};
    exc_pc    = {32'h8000_0900, 96'd0};
    exc_vaddr = {32'h5555_0001, 32'd0};
    tick();
    idle_inputs();
    tick();
    chk("rsv.save", 32'(cause_we), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rsv.busy", 32'(busy), 32'd0);
    chk("rsv.we", 32'(cause_we | epc_we | badvaddr_we),
        32'd0);
    chk("rsv.exl", 32'(exl_set | exl_clr), 32'd0);
    chk("rsv.flush", 32'(flush), 32'd0);
    chk("rsv.rv", 32'(redirect_valid), 32'd0);
    chk("rsv.epc", epc_out, 32'd0);
    chk("rsv.bv", badvaddr_out, 32'd0);
    chk("rsv.code", 32'(cause_excode), 32'd0);
    tick();
    chk("rsv.stay", 32'(busy | redirect_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
